// File: rtl/phase_branch_tracker.sv
// phase_branch_tracker
//   Per-channel max/min branch selector for the phase-recovery path. On each
//   accepted phase-found strobe, each channel keeps following the candidate
//   (max or min position) that is circularly closest to the previously chosen
//   position. Optional hysteresis, range checking, a 2-stage pipeline, a
//   restart/re-seed path and dropped-strobe reporting.
//
// Ports
//   alg_clk      clock
//   alg_rst      synchronous active-high reset
//   restart      synchronous re-seed request, flushes the pipeline
//   update       single-cycle phase-found strobe
//   pos_max      max candidates, channel k at [k*PW +: PW]
//   pos_min      min candidates, same packing
//   max_sel      per channel: max branch selected
//   min_sel      per channel: min branch selected
//   sel_valid    one-cycle pulse when the selections update
//   ref_pos      tracked reference position per channel
//   range_err    per channel: a candidate was >= PERIOD on the last decision
//   busy         pipeline holds an accepted update
//   drop_sticky  an update arrived while busy (cleared by restart)
module phase_branch_tracker #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned PW     = 12,
  parameter int unsigned PERIOD = 3600,
  parameter int unsigned HYST   = 0
) (
  input  logic              alg_clk,
  input  logic              alg_rst,
  input  logic              restart,
  input  logic              update,
  input  logic [NCH*PW-1:0] pos_max,
  input  logic [NCH*PW-1:0] pos_min,
  output logic [NCH-1:0]    max_sel,
  output logic [NCH-1:0]    min_sel,
  output logic              sel_valid,
  output logic [NCH*PW-1:0] ref_pos,
  output logic [NCH-1:0]    range_err,
  output logic              busy,
  output logic              drop_sticky
);

  // Distances need one bit beyond a position; hysteresis compare one more.
  localparam int unsigned DW = PW + 1;
  localparam int unsigned CW = PW + 2;

  typedef enum logic [0:0] {
    SEED  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic accept_c;

  // Stage-1 registers
  logic                    s1_v;
  logic                    s1_seed;
  logic [NCH*PW-1:0]       s1_max;
  logic [NCH*PW-1:0]       s1_min;
  logic [NCH-1:0][DW-1:0]  s1_dmax;
  logic [NCH-1:0][DW-1:0]  s1_dmin;
  logic [NCH-1:0]          s1_rerr;

  // Stage-1 combinational results
  logic [NCH-1:0][DW-1:0]  dmax_c;
  logic [NCH-1:0][DW-1:0]  dmin_c;
  logic [NCH-1:0]          rerr_c;

  // Stage-2 decision
  logic [NCH-1:0]          max_sel_c;
  logic [NCH-1:0]          min_sel_c;
  logic [NCH*PW-1:0]       ref_pos_c;

  // Circular distance min(|a-b|, PERIOD-|a-b|) for in-range positions.
  function automatic logic [DW-1:0] circ_dist(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    d = (a >= b) ? (DW'(a) - DW'(b)) : (DW'(b) - DW'(a));
    w = DW'(PERIOD) - d;
    return (w < d) ? w : d;
  endfunction

  // A strobe is taken only when idle; restart discards a coincident strobe.
  assign accept_c = update & ~busy & ~restart;

  // FSM state register
  always_ff @(posedge alg_clk) begin
    if (alg_rst) state_q <= SEED;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (restart)       state_d = SEED;
    else if (accept_c) state_d = TRACK;
  end

  // Range check and distances to the current reference
  always_comb begin
    dmax_c = '0;
    dmin_c = '0;
    rerr_c = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      rerr_c[k] = (DW'(pos_max[k*PW +: PW]) >= DW'(PERIOD)) ||
                  (DW'(pos_min[k*PW +: PW]) >= DW'(PERIOD));
      dmax_c[k] = circ_dist(pos_max[k*PW +: PW], ref_pos[k*PW +: PW]);
      dmin_c[k] = circ_dist(pos_min[k*PW +: PW], ref_pos[k*PW +: PW]);
    end
  end

  // Stage 1: capture candidates, distances and seed flag
  always_ff @(posedge alg_clk) begin
    if (alg_rst || restart) begin
      s1_v    <= 1'b0;
      s1_seed <= 1'b0;
      s1_max  <= '0;
      s1_min  <= '0;
      s1_dmax <= '0;
      s1_dmin <= '0;
      s1_rerr <= '0;
    end else begin
      s1_v <= accept_c;
      if (accept_c) begin
        s1_seed <= (state_q == SEED);
        s1_max  <= pos_max;
        s1_min  <= pos_min;
        s1_dmax <= dmax_c;
        s1_dmin <= dmin_c;
        s1_rerr <= rerr_c;
      end
    end
  end

  // Stage-2 branch decision per channel
  always_comb begin
    max_sel_c = max_sel;
    min_sel_c = min_sel;
    ref_pos_c = ref_pos;
    for (int k = 0; k < int'(NCH); k++) begin
      if (s1_rerr[k]) begin
        // A seed with a bad candidate leaves the channel unselected.
        if (s1_seed) begin
          max_sel_c[k]         = 1'b0;
          min_sel_c[k]         = 1'b0;
          ref_pos_c[k*PW +: PW] = '0;
        end
      end else if (s1_seed || (!max_sel[k] && !min_sel[k])) begin
        max_sel_c[k]         = 1'b1;
        min_sel_c[k]         = 1'b0;
        ref_pos_c[k*PW +: PW] = s1_max[k*PW +: PW];
      end else if (max_sel[k]) begin
        if ((CW'(s1_dmin[k]) + CW'(HYST)) < CW'(s1_dmax[k])) begin
          max_sel_c[k]         = 1'b0;
          min_sel_c[k]         = 1'b1;
          ref_pos_c[k*PW +: PW] = s1_min[k*PW +: PW];
        end else begin
          ref_pos_c[k*PW +: PW] = s1_max[k*PW +: PW];
        end
      end else begin
        if ((CW'(s1_dmax[k]) + CW'(HYST)) < CW'(s1_dmin[k])) begin
          max_sel_c[k]         = 1'b1;
          min_sel_c[k]         = 1'b0;
          ref_pos_c[k*PW +: PW] = s1_max[k*PW +: PW];
        end else begin
          ref_pos_c[k*PW +: PW] = s1_min[k*PW +: PW];
        end
      end
    end
  end

  // Stage 2: registered outputs, held between sel_valid pulses
  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      max_sel   <= '0;
      min_sel   <= '0;
      ref_pos   <= '0;
      range_err <= '0;
      sel_valid <= 1'b0;
    end else if (restart) begin
      sel_valid <= 1'b0;
    end else begin
      sel_valid <= s1_v;
      if (s1_v) begin
        max_sel   <= max_sel_c;
        min_sel   <= min_sel_c;
        ref_pos   <= ref_pos_c;
        range_err <= s1_rerr;
      end
    end
  end

  // Busy covers the two cycles after acceptance; drops are sticky
  always_ff @(posedge alg_clk) begin
    if (alg_rst || restart) begin
      busy        <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      busy <= accept_c | s1_v;
      if (update && busy) drop_sticky <= 1'b1;
    end
  end

endmodule
